colision_multi: RTL and testbench
=================================

# colision_multi

Parametrised collision, lives and bonus tracker for the seven-segment runner. On each obstacle tick it compares the hero's segment pattern against the obstacle digit in the hero's column and grants a bonus on the all-segment pattern. It maintains a lives counter with a post-hit invulnerability window and reports the win/lose verdict to the top-level game state machine. It replaces the single-life, table-driven checker and sits between the obstacle shifter and the game FSM.

## Interface
- N_DIG, 3: number of 7-segment obstacle digits on `display_obs`.
- HERO_DIG, 0: digit index (0 = bits [6:0]) in which the hero is drawn; must be < N_DIG.
- VIDAS, 3: lives at game start; 1..7.
- INVULN, 4: obstacle ticks of invulnerability after a non-fatal hit; 1..15.
- BONO_W, 4: width of the bonus counter.
- MUNDO_FIN, 2'd3: `mundo` value that means the game is won.

Ports (clock and reset first):
- clk_obstaculos  in  1  obstacle tick clock. All flops update on its falling edge.
- rst_n  in  1  asynchronous active-low reset.
- mundo  in  2  current world index.
- presente  in  3  top-level game state (OFF/WLCM/CH/GAME/WL/PA).
- display_obs  in  7*N_DIG  obstacle segments, digit k at [7k+6:7k].
- heroe  in  7  hero segment pattern.
- W_or_L  out  2  00 playing, 01 lost, 10 won; registered.
- bono_tomado  out  1  one-tick pulse when a bonus is taken.
- golpe  out  1  one-tick pulse on any hit that costs a life.
- vidas  out  3  lives remaining.
- bonos  out  BONO_W  bonuses taken this game; saturates at all-ones.

## Operation
- Obstacle digit `obs` = `display_obs[7*HERO_DIG +: 7]`.
- Bonus: `obs == 7'b1111111`. Collision: `(obs & heroe) != 0` and not bonus. `heroe == 0` never collides.
- Internal FSM: IDLE, PLAY, INMUNE, PERDIO, GANO.
- IDLE: outputs cleared, vidas = VIDAS, bonos = 0. Goes to PLAY when presente == GAME.
- PLAY, per tick, evaluated in priority order:
  - mundo == MUNDO_FIN: go to GANO, W_or_L = 10.
  - Collision with vidas == 1: vidas = 0, golpe = 1, go to PERDIO, W_or_L = 01.
  - Collision with vidas > 1: vidas - 1, golpe = 1, load the invulnerability counter with INVULN, go to INMUNE.
  - Bonus: bono_tomado = 1, bonos + 1 (saturating).
- INMUNE: collisions are ignored. Bonuses and the win check behave as in PLAY. The counter decrements each tick; when it reaches 0 the FSM returns to PLAY on that same edge.
- PERDIO and GANO are sticky: W_or_L held, no counting.
- presente == PA: all state and outputs frozen. Pulses are forced to 0.
- presente == WL: the FSM stays in its current state. It only evaluates while in PLAY or INMUNE, which covers the final tick before the game FSM reacts.
- presente in {OFF, WLCM, CH}: synchronous return to IDLE at the next edge.

## Timing
- Latency: inputs are sampled at falling edge n. The registered result is visible after edge n. The game FSM samples it on the following edge.
- Pulses (bono_tomado, golpe) last exactly one tick. There are no back-to-back golpe pulses while INMUNE.
- Reset, asynchronous at any time including mid-game: W_or_L = 00, bono_tomado = 0, golpe = 0, vidas = VIDAS, bonos = 0, FSM = IDLE, invulnerability counter = 0.
- Win and collision on the same tick: win takes priority, and no life is lost.
- Bonus counter at all-ones: bono_tomado still pulses and bonos holds.

## Configuration
- `COLISION_INVULN_EN` defined: the INMUNE state and its counter exist, as described above.
- Not defined: no INMUNE state. Every colliding tick in PLAY costs a life, so consecutive colliding ticks decrement on each tick. The INVULN parameter is ignored.

## Structure
- Shared package `heroe_pkg`:
  - game state constants OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5.
  - W_or_L encodings (JUGANDO=00, PIERDE=01, GANA=10).
  - the BONO segment constant 7'b1111111.
  - the FSM state enum.
- One sub-module, `temporizador_inmune`: loadable down-counter with a `cero` flag. Instantiated only under `COLISION_INVULN_EN`.

## Test plan
- VIDAS=3, GAME, obs=1100011, heroe=0001000 for 10 ticks: W_or_L stays 00, vidas=3, no pulses.
- Single obs=0001001 tick with heroe=0001000: golpe pulses, vidas 3→2. A hit during the next 4 ticks is ignored (macro on). A hit on tick 6 gives vidas=1.
- Third hit with vidas=1: W_or_L=01 on that edge, vidas=0. Further obstacles change nothing until presente=CH, which gives IDLE and vidas=3.
- obs=1111111 for 3 ticks: bono_tomado pulses each tick and bonos=3. With BONO_W=2, 5 bonuses give bonos=3.
- mundo=3 on the same tick as a colliding obstacle: W_or_L=10 and vidas unchanged. Also: PA mid-INMUNE freezes the counter, and resuming GAME continues the countdown.
- rst_n low mid-PERDIO: all outputs take their reset values immediately, asynchronously to clk_obstaculos.

Source files
------------

// File: rtl/heroe_pkg.sv
// Shared definitions for the seven-segment runner: game states, verdict codes,
// the bonus segment pattern and the collision tracker's FSM states.
package heroe_pkg;

  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] WLCM = 3'd1;
  localparam logic [2:0] CH   = 3'd2;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  localparam logic [1:0] JUGANDO = 2'b00;
  localparam logic [1:0] PIERDE  = 2'b01;
  localparam logic [1:0] GANA    = 2'b10;

  localparam logic [6:0] BONO = 7'b1111111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_INMUNE,
    ST_PERDIO,
    ST_GANO
  } estado_t;

endpackage

// File: rtl/temporizador_inmune.sv
// Loadable down-counter timing the post-hit invulnerability window.
// cero flags that the decrement taken on this edge leaves the counter at zero.
module temporizador_inmune #(
  parameter int             W     = 4,
  parameter logic [W-1:0]   CARGA = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic carga,
  input  logic decr,
  output logic cero
);

  logic [W-1:0] cuenta_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking here would let one update leak into another.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta_q <= '0;
    end else if (clr) begin
      cuenta_q <= '0;
    end else if (carga) begin
      cuenta_q <= CARGA;
    end else if (decr && cuenta_q != '0) begin
      cuenta_q <= cuenta_q - W'(1);
    end
  end

  assign cero = (cuenta_q <= W'(1));

endmodule

// File: rtl/colision_multi.sv
// Collision, lives and bonus tracker for the seven-segment runner.
// Optional invulnerability window after a non-fatal hit: COLISION_INVULN_EN.
module colision_multi
  import heroe_pkg::*;
#(
  parameter int         N_DIG     = 3,
  parameter int         HERO_DIG  = 0,
  parameter int         VIDAS     = 3,
  parameter int         INVULN    = 4,
  parameter int         BONO_W    = 4,
  parameter logic [1:0] MUNDO_FIN = 2'd3
) (
  input  logic                clk_obstaculos,
  input  logic                rst_n,
  input  logic [1:0]          mundo,
  input  logic [2:0]          presente,
  input  logic [7*N_DIG-1:0]  display_obs,
  input  logic [6:0]          heroe,
  output logic [1:0]          W_or_L,
  output logic                bono_tomado,
  output logic                golpe,
  output logic [2:0]          vidas,
  output logic [BONO_W-1:0]   bonos
);

  localparam logic [2:0] VIDAS_INI = 3'(VIDAS);

  logic [6:0]        obs;
  logic              es_bono, choque, gana, evalua, reinicio, fin_inmune;
  logic              unused_obs;
  estado_t           estado_q;
  logic [1:0]        w_or_l_q;
  logic              golpe_q, bono_q;
  logic [2:0]        vidas_q;
  logic [BONO_W-1:0] bonos_q;

  assign obs        = display_obs[7*HERO_DIG +: 7];
  assign unused_obs = ^display_obs;
  assign es_bono    = (obs == BONO);
  assign choque     = ((obs & heroe) != 7'd0) && !es_bono;
  assign gana       = (mundo == MUNDO_FIN);
  assign reinicio   = (presente == OFF) || (presente == WLCM) || (presente == CH);
  assign evalua     = ((presente == GAME) || (presente == WL)) &&
                      ((estado_q == ST_PLAY) || (estado_q == ST_INMUNE));

`ifdef COLISION_INVULN_EN
  logic carga_inv, decr_inv;

  assign carga_inv = evalua && (estado_q == ST_PLAY) && !gana && choque && (vidas_q > 3'd1);
  assign decr_inv  = evalua && (estado_q == ST_INMUNE);

  temporizador_inmune #(
    .W     (4),
    .CARGA (4'(INVULN))
  ) u_temporizador_inmune (
    .clk   (clk_obstaculos),
    .rst_n (rst_n),
    .clr   (reinicio),
    .carga (carga_inv),
    .decr  (decr_inv),
    .cero  (fin_inmune)
  );
`else
  logic [3:0] unused_invuln;

  // Without the window every colliding tick costs a life; INVULN has no effect.
  assign unused_invuln = 4'(INVULN);
  assign fin_inmune    = 1'b0;
`endif

  always_ff @(negedge clk_obstaculos or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ST_IDLE;
      w_or_l_q <= JUGANDO;
      golpe_q  <= 1'b0;
      bono_q   <= 1'b0;
      vidas_q  <= VIDAS_INI;
      bonos_q  <= '0;
    end else begin
      golpe_q <= 1'b0;
      bono_q  <= 1'b0;
      if (reinicio) begin
        estado_q <= ST_IDLE;
        w_or_l_q <= JUGANDO;
        vidas_q  <= VIDAS_INI;
        bonos_q  <= '0;
      end else if (estado_q == ST_IDLE) begin
        if (presente == GAME) estado_q <= ST_PLAY;
      end else if (evalua) begin
        if (gana) begin
          estado_q <= ST_GANO;
          w_or_l_q <= GANA;
        end else if (choque && estado_q == ST_PLAY) begin
          golpe_q <= 1'b1;
          if (vidas_q <= 3'd1) begin
            vidas_q  <= 3'd0;
            estado_q <= ST_PERDIO;
            w_or_l_q <= PIERDE;
          end else begin
            vidas_q <= vidas_q - 3'd1;
`ifdef COLISION_INVULN_EN
            estado_q <= ST_INMUNE;
`endif
          end
        end else begin
          if (es_bono) begin
            bono_q <= 1'b1;
            if (bonos_q != '1) bonos_q <= bonos_q + BONO_W'(1);
          end
          // The window closes on the same edge that takes the counter to zero.
          if (estado_q == ST_INMUNE && fin_inmune) estado_q <= ST_PLAY;
        end
      end
      // PA (and unused codes) leave everything frozen; PERDIO/GANO are sticky.
    end
  end

  assign W_or_L      = w_or_l_q;
  assign bono_tomado = bono_q;
  assign golpe       = golpe_q;
  assign vidas       = vidas_q;
  assign bonos       = bonos_q;

endmodule

// File: tb/tb_colision_multi.sv
// Directed bench for colision_multi; hero in digit 1 with colliding decoys in
// digits 0 and 2. Expectations adapt to COLISION_INVULN_EN.
module tb_colision_multi;
  import heroe_pkg::*;

  localparam logic [6:0] SAFE  = 7'b1100011;
  localparam logic [6:0] HIT   = 7'b0001001;
  localparam logic [6:0] BON   = 7'b1111111;
  localparam logic [6:0] HEROE = 7'b0001000;

  logic        clk = 1'b1;
  logic        rst_n;
  logic [1:0]  mundo;
  logic [2:0]  presente;
  logic [20:0] display_obs;
  logic [6:0]  heroe;
  logic [1:0]  W_or_L;
  logic        bono_tomado, golpe;
  logic [2:0]  vidas;
  logic [1:0]  bonos;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  colision_multi #(
    .N_DIG     (3),
    .HERO_DIG  (1),
    .VIDAS     (3),
    .INVULN    (4),
    .BONO_W    (2),
    .MUNDO_FIN (2'd3)
  ) dut (
    .clk_obstaculos (clk),
    .rst_n          (rst_n),
    .mundo          (mundo),
    .presente       (presente),
    .display_obs    (display_obs),
    .heroe          (heroe),
    .W_or_L         (W_or_L),
    .bono_tomado    (bono_tomado),
    .golpe          (golpe),
    .vidas          (vidas),
    .bonos          (bonos)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] mk(input logic [6:0] d);
    return {HEROE, d, HEROE};
  endfunction

  // One falling (active) edge, then return on the rising edge for checking.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] w, input logic g,
                         input logic b, input logic [2:0] v, input logic [1:0] bn);
    check({tag, ".W_or_L"},      {6'd0, W_or_L},      {6'd0, w});
    check({tag, ".golpe"},       {7'd0, golpe},       {7'd0, g});
    check({tag, ".bono_tomado"}, {7'd0, bono_tomado}, {7'd0, b});
    check({tag, ".vidas"},       {5'd0, vidas},       {5'd0, v});
    check({tag, ".bonos"},       {6'd0, bonos},       {6'd0, bn});
  endtask

  initial begin
    rst_n       = 1'b1;
    presente    = OFF;
    mundo       = 2'd0;
    heroe       = HEROE;
    display_obs = mk(SAFE);
    #1 rst_n = 1'b0;
    #1 chk_all("reset", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);
    tick();
    rst_n    = 1'b1;
    presente = GAME;
    tick();
    chk_all("enter", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("safe", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);
    end

    display_obs = mk(HIT);
    tick();
    chk_all("hit1", 2'b00, 1'b1, 1'b0, 3'd2, 2'd0);
`ifdef COLISION_INVULN_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("immune", 2'b00, 1'b0, 1'b0, 3'd2, 2'd0);
    end
`endif
    tick();
    chk_all("hit2", 2'b00, 1'b1, 1'b0, 3'd1, 2'd0);

    display_obs = mk(SAFE);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("gap", 2'b00, 1'b0, 1'b0, 3'd1, 2'd0);
    end

    display_obs = mk(HIT);
    tick();
    chk_all("lose", 2'b01, 1'b1, 1'b0, 3'd0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all("lost_hold", 2'b01, 1'b0, 1'b0, 3'd0, 2'd0);
    end
    display_obs = mk(BON);
    tick();
    chk_all("lost_bono", 2'b01, 1'b0, 1'b0, 3'd0, 2'd0);

    presente    = CH;
    display_obs = mk(SAFE);
    tick();
    chk_all("idle", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);
    presente = GAME;
    tick();
    chk_all("play2", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);

    display_obs = mk(BON);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all("bono", 2'b00, 1'b0, 1'b1, 3'd3, 2'(i));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all("bono_sat", 2'b00, 1'b0, 1'b1, 3'd3, 2'd3);
    end
    display_obs = mk(SAFE);
    tick();
    chk_all("bono_end", 2'b00, 1'b0, 1'b0, 3'd3, 2'd3);

    display_obs = mk(HIT);
    mundo       = 2'd3;
    tick();
    chk_all("win", 2'b10, 1'b0, 1'b0, 3'd3, 2'd3);
    mundo = 2'd0;
    tick();
    chk_all("win_hold", 2'b10, 1'b0, 1'b0, 3'd3, 2'd3);

    presente    = CH;
    display_obs = mk(SAFE);
    tick();
    chk_all("idle2", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);
    presente = GAME;
    tick();
    display_obs = mk(BON);
    tick();
    chk_all("bono1", 2'b00, 1'b0, 1'b1, 3'd3, 2'd1);

    display_obs = mk(HIT);
    tick();
    chk_all("hit_a", 2'b00, 1'b1, 1'b0, 3'd2, 2'd1);
`ifdef COLISION_INVULN_EN
    tick();
    chk_all("imm_a", 2'b00, 1'b0, 1'b0, 3'd2, 2'd1);
`endif
    presente = PA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("pause", 2'b00, 1'b0, 1'b0, 3'd2, 2'd1);
    end
    presente = GAME;
`ifdef COLISION_INVULN_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("imm_b", 2'b00, 1'b0, 1'b0, 3'd2, 2'd1);
    end
`endif
    tick();
    chk_all("hit_b", 2'b00, 1'b1, 1'b0, 3'd1, 2'd1);

    display_obs = mk(SAFE);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("cool", 2'b00, 1'b0, 1'b0, 3'd1, 2'd1);
    end

    presente    = WL;
    display_obs = mk(HIT);
    tick();
    chk_all("wl_lose", 2'b01, 1'b1, 1'b0, 3'd0, 2'd1);
    tick();
    chk_all("wl_hold", 2'b01, 1'b0, 1'b0, 3'd0, 2'd1);

    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);
    tick();
    chk_all("rst_held", 2'b00, 1'b0, 1'b0, 3'd3, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
